// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests on din into WIDTH-cycle high bursts on dout,
// separated by at least GAP low cycles; overlapping requests queue in a saturating counter.
module pulse_stretcher #(
  parameter int WIDTH  = 4,
  parameter int GAP    = 1,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              din,
  output logic              dout,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_WG = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CNT_W  = (MAX_WG > 1) ? $clog2(MAX_WG) : 1;

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [PEND_W-1:0]  pend_next;
  logic               ovf_next;
  logic               take_pend;
  logic               take_din;
  logic               queue_din;

  // Returns {dropped, next_count}. A simultaneous consume and enqueue cancel,
  // so a full counter only drops when nothing is leaving it that cycle.
  function automatic logic [PEND_W:0] pend_update(
    input logic [PEND_W-1:0] cur,
    input logic              take,
    input logic              queue
  );
    logic [PEND_W:0] res;
    res = {1'b0, cur};
    if (take && !queue) begin
      res = {1'b0, cur - PEND_ONE};
    end else if (!take && queue) begin
      if (cur == PEND_MAX) res = {1'b1, cur};
      else                 res = {1'b0, cur + PEND_ONE};
    end
    return res;
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    take_pend  = 1'b0;
    take_din   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (din) begin
          state_next = ST_HIGH;
          cnt_next   = HIGH_LOAD;
          take_din   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else begin
          state_next = ST_GAP;
          cnt_next   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else if (pending != '0 || din) begin
          // Queued requests are older, so they go first; din then queues behind them.
          state_next = ST_HIGH;
          cnt_next   = HIGH_LOAD;
          take_pend  = (pending != '0);
          take_din   = (pending == '0);
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    queue_din             = din && !take_din;
    {ovf_next, pend_next} = pend_update(pending, take_pend, queue_din);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dout     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      dout     <= (state_next == ST_HIGH);
      pending  <= pend_next;
      overflow <= ovf_next;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a period/queue model checked every cycle,
// literal expectations for the documented scenarios, and a WIDTH=1 round trip.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       resetn;
  logic       din;
  logic       din_rt;
  logic       dout, busy, overflow;
  logic [1:0] pending;
  logic       dout_rt, busy_rt, overflow_rt;
  logic [1:0] pending_rt;

  int n_chk = 0;
  int n_err = 0;

  pulse_stretcher #(.WIDTH(4), .GAP(1), .PEND_W(2)) dut (
    .clk(clk), .resetn(resetn), .din(din), .dout(dout),
    .busy(busy), .pending(pending), .overflow(overflow)
  );

  pulse_stretcher #(.WIDTH(1), .GAP(1), .PEND_W(2)) dut_rt (
    .clk(clk), .resetn(resetn), .din(din_rt), .dout(dout_rt),
    .busy(busy_rt), .pending(pending_rt), .overflow(overflow_rt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: phase p is the position inside a WIDTH+GAP period (-1 = idle);
  // q is the queue of accepted-but-unstarted requests.
  task automatic mstep(input int w, input int g, input int qmax, input logic d,
                       input logic r, inout int p, inout int q,
                       output logic ovf, output logic acc);
    logic consumed;
    consumed = 1'b0;
    ovf      = 1'b0;
    acc      = 1'b0;
    if (!r) begin
      p = -1;
      q = 0;
    end else begin
      if (p < 0) begin
        if (d) begin p = 0; consumed = 1'b1; end
      end else if (p < w + g - 1) begin
        p++;
      end else if (q > 0) begin
        q--;
        p = 0;
      end else if (d) begin
        p = 0;
        consumed = 1'b1;
      end else begin
        p = -1;
      end
      if (d && !consumed) begin
        if (q == qmax) ovf = 1'b1;
        else           q++;
      end
      acc = d && !ovf;
    end
  endtask

  int   mp = -1, mq = 0, rp = -1, rq = 0;
  logic movf = 1'b0, rovf = 1'b0;
  int   racc = 0;
  logic started = 1'b0;

  always @(posedge clk) begin
    logic a;
    if (!resetn) started = 1'b1;
    mstep(4, 1, 3, din, resetn, mp, mq, movf, a);
    mstep(1, 1, 3, din_rt, resetn, rp, rq, rovf, a);
    if (a) racc++;
  end

  int   rise_m = 0, rise_r = 0;
  logic prev_m = 1'b0, prev_r = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      chk("m_dout", int'(dout), int'(mp >= 0 && mp < 4));
      chk("m_busy", int'(busy), int'(mp >= 0));
      chk("m_pending", int'(pending), mq);
      chk("m_overflow", int'(overflow), int'(movf));
      chk("rt_dout", int'(dout_rt), int'(rp == 0));
      chk("rt_busy", int'(busy_rt), int'(rp >= 0));
      chk("rt_pending", int'(pending_rt), rq);
      chk("rt_overflow", int'(overflow_rt), int'(rovf));
      if (dout && !prev_m) rise_m++;
      if (dout_rt && !prev_r) rise_r++;
      prev_m = dout;
      prev_r = dout_rt;
    end
  end

  task automatic step(input logic d);
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 60 && busy; i++) step(1'b0);
    chk(nm, int'(busy), 0);
  endtask

  initial begin
    int rc0;
    resetn = 1'b0;
    din    = 1'b1;
    din_rt = 1'b0;
    repeat (3) step(1'b1);
    chk("reset_dout", int'(dout), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_overflow", int'(overflow), 0);
    resetn = 1'b1;
    step(1'b0);

    // Single request
    step(1'b1);
    chk("t1_dout_t1", int'(dout), 1);
    chk("t1_busy_t1", int'(busy), 1);
    repeat (3) step(1'b0);
    chk("t1_dout_t4", int'(dout), 1);
    step(1'b0);
    chk("t1_dout_t5", int'(dout), 0);
    chk("t1_busy_t5", int'(busy), 1);
    step(1'b0);
    chk("t1_busy_t6", int'(busy), 0);
    chk("t1_pending", int'(pending), 0);
    step(1'b0);

    // Back-to-back requests
    step(1'b1);
    step(1'b1);
    chk("t2_pending_t2", int'(pending), 1);
    repeat (3) step(1'b0);
    chk("t2_pending_t5", int'(pending), 1);
    chk("t2_dout_t5", int'(dout), 0);
    step(1'b0);
    chk("t2_dout_t6", int'(dout), 1);
    chk("t2_pending_t6", int'(pending), 0);
    repeat (3) step(1'b0);
    chk("t2_dout_t9", int'(dout), 1);
    step(1'b0);
    chk("t2_dout_t10", int'(dout), 0);
    wait_idle("t2_idle");
    step(1'b0);

    // Overflow
    rc0 = rise_m;
    step(1'b1);
    step(1'b1);
    chk("t3_pending_t2", int'(pending), 1);
    step(1'b1);
    chk("t3_pending_t3", int'(pending), 2);
    step(1'b1);
    chk("t3_pending_t4", int'(pending), 3);
    chk("t3_overflow_t4", int'(overflow), 0);
    step(1'b1);
    chk("t3_overflow_t5", int'(overflow), 1);
    chk("t3_pending_t5", int'(pending), 3);
    step(1'b0);
    chk("t3_overflow_t6", int'(overflow), 0);
    wait_idle("t3_idle");
    chk("t3_bursts", rise_m - rc0, 4);
    step(1'b0);

    // Coincident request at gap end
    step(1'b1);
    repeat (4) step(1'b0);
    chk("t4_dout_t5", int'(dout), 0);
    step(1'b1);
    chk("t4_dout_t6", int'(dout), 1);
    chk("t4_pending_t6", int'(pending), 0);
    repeat (3) step(1'b0);
    chk("t4_dout_t9", int'(dout), 1);
    chk("t4_pending_t9", int'(pending), 0);
    step(1'b0);
    chk("t4_dout_t10", int'(dout), 0);
    wait_idle("t4_idle");

    // Reset mid-burst
    step(1'b1);
    step(1'b1);
    resetn = 1'b0;
    step(1'b1);
    chk("t5_dout", int'(dout), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_pending", int'(pending), 0);
    resetn = 1'b1;
    repeat (3) step(1'b0);
    chk("t5_dout_after", int'(dout), 0);
    chk("t5_busy_after", int'(busy), 0);

    // Round trip, WIDTH=1
    for (int i = 0; i < 300; i++) begin
      din_rt = ($urandom_range(0, 2) == 0);
      step(1'b0);
    end
    din_rt = 1'b0;
    for (int i = 0; i < 40 && busy_rt; i++) step(1'b0);
    chk("t6_idle", int'(busy_rt), 0);
    step(1'b0);
    chk("t6_pulse_count", rise_r, racc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
